// File: rtl/btn_event_array.sv
// N-channel push-button front end: sync, debounce, press/release/long/repeat events.
// Define BTN_AUTOREPEAT_EN to build the LONG_HELD repeat counter and btn_repeat pulses.

module btn_event_lane #(
  parameter int DEBOUNCE_US = 20000,
  parameter int LONG_US     = 1000000,
`ifdef BTN_AUTOREPEAT_EN
  parameter int REPEAT_US   = 200000,
`endif
  parameter int ACTIVE_LOW  = 0,
  parameter int CW          = 21
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_hit,
  output logic rep
);

  typedef enum logic [2:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    LONG_HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic          POL       = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_US - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_US - 1);
  localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_US);

  logic [1:0]    sync;
  logic          on;
  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [CW-1:0] hold, hold_d;
  logic          from_long, from_long_d;
  logic          level_d, press_d, rel_d, long_d;

  assign on = sync[1];

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_US - 1);
  logic [CW-1:0] rep_cnt, rep_cnt_d;
  logic          rep_q, rep_d;
  assign rep = rep_q;
`else
  assign rep = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync      <= 2'b00;
      state     <= RELEASED;
      cnt       <= '0;
      hold      <= '0;
      from_long <= 1'b0;
      level     <= 1'b0;
      press     <= 1'b0;
      rel       <= 1'b0;
      long_hit  <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt   <= '0;
      rep_q     <= 1'b0;
`endif
    end else begin
      sync      <= {sync[0], raw ^ POL};
      state     <= state_d;
      cnt       <= cnt_d;
      hold      <= hold_d;
      from_long <= from_long_d;
      level     <= level_d;
      press     <= press_d;
      rel       <= rel_d;
      long_hit  <= long_d;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt   <= rep_cnt_d;
      rep_q     <= rep_d;
`endif
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    hold_d      = hold;
    from_long_d = from_long;
    level_d     = level;
    press_d     = 1'b0;
    rel_d       = 1'b0;
    long_d      = 1'b0;

    // Hold time keeps running through a release bounce so long-press timing is unaffected.
    if ((state == PRESSED || (state == RELEASE_WAIT && !from_long)) && hold != LONG_SAT)
      hold_d = hold + CW'(1);

`ifdef BTN_AUTOREPEAT_EN
    rep_cnt_d = rep_cnt;
    rep_d     = 1'b0;
    if (state == LONG_HELD || (state == RELEASE_WAIT && from_long))
      rep_cnt_d = (rep_cnt == REP_LAST) ? '0 : rep_cnt + CW'(1);
    if (state == LONG_HELD && on && rep_cnt == REP_LAST)
      rep_d = 1'b1;
`endif

    case (state)
      RELEASED: begin
        if (on) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!on) begin
          state_d = RELEASED;
        end else if (cnt == DB_LAST) begin
          state_d     = PRESSED;
          level_d     = 1'b1;
          press_d     = 1'b1;
          hold_d      = '0;
          from_long_d = 1'b0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!on) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (hold >= LONG_LAST) begin
          state_d     = LONG_HELD;
          long_d      = 1'b1;
          from_long_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          rep_cnt_d   = '0;
`endif
        end
      end
      LONG_HELD: begin
        if (!on) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (on) begin
          state_d = from_long ? LONG_HELD : PRESSED;
        end else if (cnt == DB_LAST) begin
          state_d = RELEASED;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
  end

endmodule

module btn_event_array #(
  parameter int NUM_BTN     = 4,
  parameter int DEBOUNCE_US = 20000,
  parameter int LONG_US     = 1000000,
  parameter int REPEAT_US   = 200000,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic               clk_1MHz,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic [NUM_BTN-1:0] btn_repeat
);

  localparam int MAX_A = (DEBOUNCE_US > LONG_US) ? DEBOUNCE_US : LONG_US;
  localparam int MAX_P = (MAX_A > REPEAT_US) ? MAX_A : REPEAT_US;
  localparam int CW    = $clog2(MAX_P) + 1;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
    btn_event_lane #(
      .DEBOUNCE_US (DEBOUNCE_US),
      .LONG_US     (LONG_US),
`ifdef BTN_AUTOREPEAT_EN
      .REPEAT_US   (REPEAT_US),
`endif
      .ACTIVE_LOW  (ACTIVE_LOW),
      .CW          (CW)
    ) u_lane (
      .clk      (clk_1MHz),
      .rst_n    (rst_n),
      .raw      (btn_in[g]),
      .level    (btn_level[g]),
      .press    (btn_press[g]),
      .rel      (btn_release[g]),
      .long_hit (btn_long[g]),
      .rep      (btn_repeat[g])
    );
  end

endmodule

// File: tb/tb_btn_event_array.sv
// Directed bench for btn_event_array: DEBOUNCE=8, LONG=40, REPEAT=10, active-high inputs.
// Repeat expectations follow BTN_AUTOREPEAT_EN.

module tb_btn_event_array;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn_in;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int press_n [NB];
  int press_at[NB];
  int rel_n   [NB];
  int rel_at  [NB];
  int long_n  [NB];
  int long_at [NB];
  int rep_n   [NB];
  int rep_at  [NB][16];
  int both_n  = 0;

  btn_event_array #(
    .NUM_BTN     (NB),
    .DEBOUNCE_US (8),
    .LONG_US     (40),
    .REPEAT_US   (10),
    .ACTIVE_LOW  (0)
  ) dut (
    .clk_1MHz    (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .btn_repeat  (btn_repeat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle; times are the edge count at which the pulse appeared.
  always @(negedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (btn_press[i] === 1'b1)   begin press_n[i]++; press_at[i] = cyc; end
      if (btn_release[i] === 1'b1) begin rel_n[i]++;   rel_at[i]   = cyc; end
      if (btn_long[i] === 1'b1)    begin long_n[i]++;  long_at[i]  = cyc; end
      if (btn_repeat[i] === 1'b1)  begin rep_at[i][rep_n[i] % 16] = cyc; rep_n[i]++; end
      if (btn_press[i] === 1'b1 && btn_release[i] === 1'b1) both_n++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int ev_total();
    int s = 0;
    for (int i = 0; i < NB; i++) s += press_n[i] + rel_n[i] + long_n[i] + rep_n[i];
    return s;
  endfunction

  task automatic test_reset();
    rst_n  = 1'b0;
    btn_in = '0;
    step(3);
    total++;
    if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 00000",
               {btn_level, btn_press, btn_release, btn_long, btn_repeat});
    end
    rst_n = 1'b1;
    step(12);
    total++;
    if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} !== 20'h0) begin
      bad++;
      $display("FAIL idle_outputs: got %h want 00000",
               {btn_level, btn_press, btn_release, btn_long, btn_repeat});
    end
  endtask

  task automatic test_clean_press();
    int bp = press_n[0], br = rel_n[0], bl = long_n[0], e, f;
    btn_in[0] = 1'b1;
    e = cyc;
    step(20);
    total++;
    if (press_n[0] - bp !== 1) begin
      bad++; $display("FAIL clean_press_count: got %0d want 1", press_n[0] - bp);
    end
    total++;
    if (press_at[0] - e < 10 || press_at[0] - e > 12) begin
      bad++; $display("FAIL clean_press_latency: got %0d want 10..12", press_at[0] - e);
    end
    total++;
    if (btn_level[0] !== 1'b1) begin
      bad++; $display("FAIL clean_level_high: got %b want 1", btn_level[0]);
    end
    total++;
    if (long_n[0] - bl !== 0) begin
      bad++; $display("FAIL clean_no_long: got %0d want 0", long_n[0] - bl);
    end
    btn_in[0] = 1'b0;
    f = cyc;
    step(15);
    total++;
    if (rel_n[0] - br !== 1) begin
      bad++; $display("FAIL clean_release_count: got %0d want 1", rel_n[0] - br);
    end
    total++;
    if (rel_at[0] - f < 10 || rel_at[0] - f > 12) begin
      bad++; $display("FAIL clean_release_latency: got %0d want 10..12", rel_at[0] - f);
    end
    total++;
    if (btn_level[0] !== 1'b0) begin
      bad++; $display("FAIL clean_level_low: got %b want 0", btn_level[0]);
    end
  endtask

  task automatic test_bounce();
    int b = ev_total(), bp, br;
    btn_in[1] = 1'b1; step(5);
    btn_in[1] = 1'b0; step(2);
    btn_in[1] = 1'b1; step(5);
    btn_in[1] = 1'b0; step(15);
    total++;
    if (ev_total() - b !== 0) begin
      bad++; $display("FAIL bounce_no_events: got %0d want 0", ev_total() - b);
    end
    total++;
    if (btn_level !== 4'b0000) begin
      bad++; $display("FAIL bounce_level: got %b want 0000", btn_level);
    end
    bp = press_n[1];
    br = rel_n[1];
    btn_in[1] = 1'b1;
    step(14);
    total++;
    if (press_n[1] - bp !== 1) begin
      bad++; $display("FAIL bounce_steady_press: got %0d want 1", press_n[1] - bp);
    end
    btn_in[1] = 1'b0;
    step(15);
    total++;
    if (rel_n[1] - br !== 1 || btn_level[1] !== 1'b0) begin
      bad++; $display("FAIL bounce_release: got %0d/%b want 1/0", rel_n[1] - br, btn_level[1]);
    end
  endtask

  task automatic test_long_repeat();
    int bp = press_n[2], bl = long_n[2], br = rel_n[2], brp = rep_n[2], e;
    btn_in[2] = 1'b1;
    e = cyc;
    step(100);
    btn_in[2] = 1'b0;
    step(30);
    total++;
    if (press_n[2] - bp !== 1 || long_n[2] - bl !== 1) begin
      bad++; $display("FAIL long_counts: got press=%0d long=%0d want 1/1",
                      press_n[2] - bp, long_n[2] - bl);
    end
    total++;
    if (long_at[2] - press_at[2] !== 40) begin
      bad++; $display("FAIL long_timing: got %0d want 40", long_at[2] - press_at[2]);
    end
`ifdef BTN_AUTOREPEAT_EN
    total++;
    if (rep_n[2] - brp !== 5) begin
      bad++; $display("FAIL repeat_count: got %0d want 5", rep_n[2] - brp);
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (rep_at[2][(brp + k) % 16] - long_at[2] !== 10 * (k + 1)) begin
        bad++; $display("FAIL repeat_timing_%0d: got %0d want %0d", k,
                        rep_at[2][(brp + k) % 16] - long_at[2], 10 * (k + 1));
      end
    end
`else
    total++;
    if (rep_n[2] - brp !== 0) begin
      bad++; $display("FAIL repeat_disabled: got %0d want 0", rep_n[2] - brp);
    end
`endif
    total++;
    if (rel_n[2] - br !== 1 || btn_level[2] !== 1'b0) begin
      bad++; $display("FAIL long_release: got %0d/%b want 1/0", rel_n[2] - br, btn_level[2]);
    end
  endtask

  task automatic test_simul_glitch();
    int bp0 = press_n[0], bp3 = press_n[3], br3 = rel_n[3];
    btn_in[0] = 1'b1;
    btn_in[3] = 1'b1;
    step(20);
    total++;
    if (press_n[0] - bp0 !== 1 || press_n[3] - bp3 !== 1) begin
      bad++; $display("FAIL simul_press_count: got %0d/%0d want 1/1",
                      press_n[0] - bp0, press_n[3] - bp3);
    end
    total++;
    if (press_at[0] !== press_at[3]) begin
      bad++; $display("FAIL simul_press_same_cycle: got %0d vs %0d", press_at[0], press_at[3]);
    end
    btn_in[3] = 1'b0;
    step(3);
    btn_in[3] = 1'b1;
    step(37);
    total++;
    if (rel_n[3] - br3 !== 0 || btn_level[3] !== 1'b1) begin
      bad++; $display("FAIL glitch_no_release: got %0d/%b want 0/1", rel_n[3] - br3, btn_level[3]);
    end
    total++;
    if (long_at[3] - press_at[3] !== 40) begin
      bad++; $display("FAIL glitch_long_timing: got %0d want 40", long_at[3] - press_at[3]);
    end
    total++;
    if (long_at[0] - press_at[0] !== 40) begin
      bad++; $display("FAIL ch0_long_timing: got %0d want 40", long_at[0] - press_at[0]);
    end
    btn_in[3] = 1'b0;
    step(15);
    total++;
    if (rel_n[3] - br3 !== 1 || btn_level !== 4'b0001) begin
      bad++; $display("FAIL ch3_release: got %0d/%b want 1/0001", rel_n[3] - br3, btn_level);
    end
  endtask

  task automatic test_reset_mid();
    int bp = press_n[0], br = rel_n[0], r;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    r = cyc;
    total++;
    if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} !== 20'h0) begin
      bad++; $display("FAIL midreset_outputs: got %h want 00000",
                      {btn_level, btn_press, btn_release, btn_long, btn_repeat});
    end
    step(15);
    total++;
    if (rel_n[0] - br !== 0) begin
      bad++; $display("FAIL midreset_no_release: got %0d want 0", rel_n[0] - br);
    end
    total++;
    if (press_n[0] - bp !== 1) begin
      bad++; $display("FAIL midreset_repress_count: got %0d want 1", press_n[0] - bp);
    end
    total++;
    if (press_at[0] - r < 9 || press_at[0] - r > 12) begin
      bad++; $display("FAIL midreset_repress_latency: got %0d want 9..12", press_at[0] - r);
    end
    btn_in[0] = 1'b0;
    step(15);
    total++;
    if (btn_level !== 4'b0000) begin
      bad++; $display("FAIL final_level: got %b want 0000", btn_level);
    end
  endtask

  task automatic test_no_overlap();
    total++;
    if (both_n !== 0) begin
      bad++; $display("FAIL press_release_overlap: got %0d want 0", both_n);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_simul_glitch();
    test_reset_mid();
    test_no_overlap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
